// File: rtl/psum_pkg.sv
// Shared defaults for the systolic array output collector.
package psum_pkg;
  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int DEPTH   = 64;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
endpackage

// File: rtl/psum_fifo_col.sv
// One show-ahead column FIFO of partial sums.
// Occupancy is kept separately from the pointers so full and empty are unambiguous.
module psum_fifo_col
  import psum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [psum_bw-1:0]      din,
  output logic [psum_bw-1:0]      dout,
  output logic [$clog2(depth):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] cnt_zero = {cnt_w{1'b0}};
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(depth);

  logic [psum_bw-1:0] mem_r [depth];
  logic [ptr_w-1:0]   wr_ptr_r;
  logic [ptr_w-1:0]   rd_ptr_r;
  logic [cnt_w-1:0]   count_r;
  logic               push_s;
  logic               pop_s;

  // A full column still accepts a write when it pops on the same edge.
  always_comb begin
    pop_s  = rd && (count_r != cnt_zero);
    push_s = wr && ((count_r != cnt_full) || pop_s);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {ptr_w{1'b0}};
      rd_ptr_r <= {ptr_w{1'b0}};
      count_r  <= cnt_zero;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is intentionally not reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end

  // Head view and status decode from registered occupancy.
  always_comb begin
    if (count_r == cnt_zero) begin
      dout = {psum_bw{1'b0}};
    end else begin
      dout = mem_r[rd_ptr_r];
    end
    count = count_r;
    full  = (count_r == cnt_full);
    empty = (count_r == cnt_zero);
  end
endmodule

// File: rtl/psum_collector.sv
// Collects column-skewed psums from the array south edge into per-column FIFOs
// and presents aligned rows to the downstream writer.
module psum_collector
  import psum_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int depth   = DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [psum_bw*col-1:0]   in_s,
  input  logic [col-1:0]           in_valid,
  input  logic                     rd,
  output logic [psum_bw*col-1:0]   out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_ovf,
  output logic [$clog2(depth):0]   row_cnt
);
  localparam int cnt_w = $clog2(depth) + 1;

  if ((bw < 1) || (depth < 4) || ((depth & (depth - 1)) != 0)) begin : g_param_check
    $error("psum_collector: bw must be >= 1 and depth a power of 2 >= 4");
  end

  logic [col-1:0]   empty_s;
  logic [col-1:0]   full_s;
  logic [cnt_w-1:0] count_s [col];
  logic [col-1:0]   drop_s;
  logic             pop_s;
  logic [cnt_w-1:0] min_s;
  logic             ovf_r;

  assign pop_s = rd && o_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    psum_fifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (in_valid[c]),
      .rd    (pop_s),
      .din   (in_s[psum_bw*c +: psum_bw]),
      .dout  (out[psum_bw*c +: psum_bw]),
      .count (count_s[c]),
      .full  (full_s[c]),
      .empty (empty_s[c])
    );
  end

  // Row-level status: all-non-empty, any-full, dropped writes and min occupancy.
  always_comb begin
    o_valid = ~|empty_s;
    o_full  = |full_s;
    drop_s  = in_valid & full_s & ~{col{pop_s}};
    min_s   = cnt_w'(depth);
    for (int c = 0; c < col; c++) begin
      if (count_s[c] < min_s) begin
        min_s = count_s[c];
      end else begin
        min_s = min_s;
      end
    end
    row_cnt = min_s;
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_r <= 1'b0;
    end else if (|drop_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign o_ovf = ovf_r;
endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector: hand table for full/overflow cases,
// directed skew/partial/wrap sequences and random traffic against a queue model.
module tb_psum_collector;
  localparam int PBW = 16;
  localparam int NC  = 8;
  localparam int DEP = 4;
  localparam int CW  = $clog2(DEP) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [PBW*NC-1:0] in_s = '0;
  logic [NC-1:0]     in_valid = '0;
  logic              rd = 1'b0;
  logic [PBW*NC-1:0] out;
  logic              o_valid, o_full, o_ovf;
  logic [CW-1:0]     row_cnt;

  always #5 clk = ~clk;

  psum_collector #(.bw(4), .psum_bw(PBW), .col(NC), .depth(DEP)) dut (
    .clk(clk), .reset(reset), .in_s(in_s), .in_valid(in_valid), .rd(rd),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ovf(o_ovf), .row_cnt(row_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one queue per column plus the sticky overflow bit.
  logic [PBW-1:0] mq [NC][$];
  logic           m_ovf = 1'b0;

  typedef struct {
    logic          rst;
    logic [NC-1:0] val;
    int            base;
    logic          rdi;
    logic          e_v;
    logic          e_f;
    logic          e_ovf;
    int            e_rc;
    int            e_head;
  } vec_t;

  function automatic logic [PBW*NC-1:0] row(input int base);
    logic [PBW*NC-1:0] r;
    for (int c = 0; c < NC; c++) r[c*PBW +: PBW] = PBW'(base + c);
    return r;
  endfunction

  function automatic vec_t mk(input logic rst, input logic [NC-1:0] val, input int base,
                              input logic rdi, input logic e_v, input logic e_f,
                              input logic e_ovf, input int e_rc, input int e_head);
    vec_t v;
    v.rst = rst; v.val = val; v.base = base; v.rdi = rdi;
    v.e_v = e_v; v.e_f = e_f; v.e_ovf = e_ovf; v.e_rc = e_rc; v.e_head = e_head;
    return v;
  endfunction

  task automatic model_edge();
    logic pop;
    if (!reset) begin
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_ovf = 1'b0;
    end else begin
      pop = rd;
      for (int c = 0; c < NC; c++) if (mq[c].size() == 0) pop = 1'b0;
      for (int c = 0; c < NC; c++) begin
        if (pop) void'(mq[c].pop_front());
        if (in_valid[c]) begin
          if (mq[c].size() < DEP) mq[c].push_back(in_s[c*PBW +: PBW]);
          else m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model(input string name);
    logic [PBW*NC-1:0] e_out;
    logic e_v, e_f;
    int   e_rc;
    e_out = '0; e_v = 1'b1; e_f = 1'b0; e_rc = DEP;
    for (int c = 0; c < NC; c++) begin
      if (mq[c].size() == 0) e_v = 1'b0;
      else e_out[c*PBW +: PBW] = mq[c][0];
      if (mq[c].size() == DEP) e_f = 1'b1;
      if (mq[c].size() < e_rc) e_rc = mq[c].size();
    end
    vectors++;
    if (out !== e_out || o_valid !== e_v || o_full !== e_f || o_ovf !== m_ovf || row_cnt !== CW'(e_rc)) begin
      miscompares++;
      $display("FAIL %s: got out=%h v=%b f=%b ovf=%b rc=%0d, want out=%h v=%b f=%b ovf=%b rc=%0d",
               name, out, o_valid, o_full, o_ovf, row_cnt, e_out, e_v, e_f, m_ovf, e_rc);
    end
  endtask

  task automatic step(input logic r, input logic [NC-1:0] v, input logic [PBW*NC-1:0] d,
                      input logic rdi, input string name);
    reset = r; in_valid = v; in_s = d; rd = rdi;
    @(posedge clk);
    model_edge();
    #1;
    check_model(name);
  endtask

  task automatic apply_vec(input vec_t t, input int idx);
    logic [PBW*NC-1:0] e_out;
    reset = t.rst; in_valid = t.val; in_s = row(t.base); rd = t.rdi;
    @(posedge clk);
    model_edge();
    #1;
    e_out = t.e_v ? row(t.e_head) : '0;
    vectors++;
    if (out !== e_out || o_valid !== t.e_v || o_full !== t.e_f || o_ovf !== t.e_ovf || row_cnt !== CW'(t.e_rc)) begin
      miscompares++;
      $display("FAIL table[%0d]: got out=%h v=%b f=%b ovf=%b rc=%0d, want out=%h v=%b f=%b ovf=%b rc=%0d",
               idx, out, o_valid, o_full, o_ovf, row_cnt, e_out, t.e_v, t.e_f, t.e_ovf, t.e_rc);
    end
  endtask

  initial begin
    vec_t tbl [$];
    logic [PBW*NC-1:0] d;
    logic [NC-1:0] v;

    // Reset with garbage traffic, then release.
    for (int i = 0; i < 3; i++)
      step(1'b0, NC'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), "reset_hold");
    step(1'b1, '0, '0, 1'b0, "reset_release");

    // Skewed fill: column c gets 16r+c at cycle r+c.
    for (int t = 0; t < 11; t++) begin
      v = '0; d = '0;
      for (int c = 0; c < NC; c++) begin
        if (t - c >= 0 && t - c <= 3) begin
          v[c] = 1'b1;
          d[c*PBW +: PBW] = PBW'(16 * (t - c) + c);
        end
      end
      step(1'b1, v, d, 1'b0, "skew_fill");
    end
    for (int i = 0; i < 5; i++) step(1'b1, '0, '0, 1'b1, "skew_drain");

    // Partial columns: 3 entries in columns 0-6, one in column 7.
    step(1'b0, '0, '0, 1'b0, "partial_reset");
    step(1'b1, 8'hFF, row(16'h100), 1'b0, "partial_w0");
    step(1'b1, 8'h7F, row(16'h200), 1'b0, "partial_w1");
    step(1'b1, 8'h7F, row(16'h300), 1'b0, "partial_w2");
    step(1'b1, '0, '0, 1'b1, "partial_rd");
    step(1'b1, '0, '0, 1'b1, "partial_rd_ignored");
    step(1'b1, '0, '0, 1'b0, "partial_hold");

    // Table: overflow at depth 4, then simultaneous push/pop at full.
    tbl.push_back(mk(1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
    tbl.push_back(mk(1'b1, 8'hFF, 'h00,  1'b0, 1'b1, 1'b0, 1'b0, 1, 'h00));
    tbl.push_back(mk(1'b1, 8'hFF, 'h10,  1'b0, 1'b1, 1'b0, 1'b0, 2, 'h00));
    tbl.push_back(mk(1'b1, 8'hFF, 'h20,  1'b0, 1'b1, 1'b0, 1'b0, 3, 'h00));
    tbl.push_back(mk(1'b1, 8'hFF, 'h30,  1'b0, 1'b1, 1'b1, 1'b0, 4, 'h00));
    tbl.push_back(mk(1'b1, 8'hFF, 'h40,  1'b0, 1'b1, 1'b1, 1'b1, 4, 'h00));
    tbl.push_back(mk(1'b1, 8'h00, 0,     1'b1, 1'b1, 1'b0, 1'b1, 3, 'h10));
    tbl.push_back(mk(1'b1, 8'hFF, 'h50,  1'b1, 1'b1, 1'b0, 1'b1, 3, 'h20));
    tbl.push_back(mk(1'b1, 8'h00, 0,     1'b1, 1'b1, 1'b0, 1'b1, 2, 'h30));
    tbl.push_back(mk(1'b1, 8'h00, 0,     1'b1, 1'b1, 1'b0, 1'b1, 1, 'h50));
    tbl.push_back(mk(1'b1, 8'h00, 0,     1'b1, 1'b0, 1'b0, 1'b1, 0, 0));
    tbl.push_back(mk(1'b1, 8'h00, 0,     1'b1, 1'b0, 1'b0, 1'b1, 0, 0));
    tbl.push_back(mk(1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
    tbl.push_back(mk(1'b1, 8'hFF, 'h00,  1'b0, 1'b1, 1'b0, 1'b0, 1, 'h00));
    tbl.push_back(mk(1'b1, 8'hFF, 'h10,  1'b0, 1'b1, 1'b0, 1'b0, 2, 'h00));
    tbl.push_back(mk(1'b1, 8'hFF, 'h20,  1'b0, 1'b1, 1'b0, 1'b0, 3, 'h00));
    tbl.push_back(mk(1'b1, 8'hFF, 'h30,  1'b0, 1'b1, 1'b1, 1'b0, 4, 'h00));
    tbl.push_back(mk(1'b1, 8'hFF, 99,    1'b1, 1'b1, 1'b1, 1'b0, 4, 'h10));
    tbl.push_back(mk(1'b1, 8'h00, 0,     1'b1, 1'b1, 1'b0, 1'b0, 3, 'h20));
    tbl.push_back(mk(1'b1, 8'h00, 0,     1'b1, 1'b1, 1'b0, 1'b0, 2, 'h30));
    tbl.push_back(mk(1'b1, 8'h00, 0,     1'b1, 1'b1, 1'b0, 1'b0, 1, 99));
    tbl.push_back(mk(1'b1, 8'h00, 0,     1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

    // Wrap-around streaming with a pop every cycle.
    for (int k = 0; k < 3 * DEP + 1; k++)
      step(1'b1, 8'hFF, row(16'h400 + 16 * k), 1'b1, "wrap_stream");
    step(1'b1, '0, '0, 1'b1, "wrap_drain");

    // Mid-run reset with two rows stored; stale rows must not reappear.
    step(1'b1, 8'hFF, row(16'h800), 1'b0, "midreset_w0");
    step(1'b1, 8'hFF, row(16'h810), 1'b0, "midreset_w1");
    step(1'b0, 8'hFF, row(16'h820), 1'b1, "midreset_assert");
    step(1'b1, '0, '0, 1'b1, "midreset_release");
    step(1'b1, 8'hFF, row(16'h900), 1'b0, "midreset_fresh");
    step(1'b1, '0, '0, 1'b1, "midreset_pop");

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) == 0) ? 8'hFF : NC'($urandom);
      step(($urandom_range(0, 99) != 0), v, {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 2) != 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
